decrypt_prga: RTL

//  RC4 pseudo-random generation + decrypt stage; runs after the key-schedule swap stage has permuted S.

---
 rtl/decrypt_prga.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/decrypt_prga.sv
// decrypt_prga
//   RC4 keystream generation and decrypt stage. Runs after the key-schedule
//   swap stage has permuted S. For each message byte it steps i/j through the
//   shared S table, swaps S[i]/S[j], fetches the keystream byte
//   S[S[i]+S[j]], XORs it with the encrypted ROM byte and writes the result
//   to the decrypted-message RAM.
// Ports
//   clk, reset_n             clock (rising edge), async active-low reset
//   start_flag / done_flag   stage handshake (start level, done while in DONE)
//   s_address/s_data_in/s_q/s_wren   shared 256x8 S memory port
//   rom_address/rom_q        encrypted-message ROM (address = byte index k)
//   d_address/d_data_in/d_wren       decrypted-message RAM write port
// Every output is a register. Values that must be visible *during* a write
// state (WR_I, WR_J, WR_D) are therefore loaded on the edge entering it.
module decrypt_prga #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_flag,
    output logic              done_flag,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data_in,
    input  logic [7:0]        s_q,
    output logic              s_wren,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] d_address,
    output logic [7:0]        d_data_in,
    output logic              d_wren
);

    typedef enum logic [3:0] {
        IDLE, SET_I, WAIT_I, GET_I, ADD_J, WAIT_J, GET_J,
        WR_I, WR_J, SET_F, WAIT_F, GET_F, WR_D, NEXT, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        i, j, si, sj, f;
    logic [7:0]        i_nxt, j_nxt, si_nxt, sj_nxt, f_nxt;
    logic [MSG_AW-1:0] k, k_nxt;

    logic              done_nxt, s_wren_nxt, d_wren_nxt;
    logic [7:0]        s_addr_nxt, s_data_nxt, d_data_nxt;
    logic [MSG_AW-1:0] rom_addr_nxt, d_addr_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            sj          <= '0;
            f           <= '0;
            done_flag   <= 1'b0;
            s_address   <= '0;
            s_data_in   <= '0;
            s_wren      <= 1'b0;
            rom_address <= '0;
            d_address   <= '0;
            d_data_in   <= '0;
            d_wren      <= 1'b0;
        end else begin
            state       <= state_nxt;
            i           <= i_nxt;
            j           <= j_nxt;
            k           <= k_nxt;
            si          <= si_nxt;
            sj          <= sj_nxt;
            f           <= f_nxt;
            done_flag   <= done_nxt;
            s_address   <= s_addr_nxt;
            s_data_in   <= s_data_nxt;
            s_wren      <= s_wren_nxt;
            rom_address <= rom_addr_nxt;
            d_address   <= d_addr_nxt;
            d_data_in   <= d_data_nxt;
            d_wren      <= d_wren_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        i_nxt        = i;
        j_nxt        = j;
        k_nxt        = k;
        si_nxt       = si;
        sj_nxt       = sj;
        f_nxt        = f;
        done_nxt     = done_flag;
        s_addr_nxt   = s_address;
        s_data_nxt   = s_data_in;
        s_wren_nxt   = s_wren;
        rom_addr_nxt = rom_address;
        d_addr_nxt   = d_address;
        d_data_nxt   = d_data_in;
        d_wren_nxt   = d_wren;

        case (state)
            IDLE: begin
                i_nxt        = '0;
                j_nxt        = '0;
                k_nxt        = '0;
                rom_addr_nxt = '0;
                s_addr_nxt   = '0;
                s_data_nxt   = '0;
                s_wren_nxt   = 1'b0;
                d_addr_nxt   = '0;
                d_data_nxt   = '0;
                d_wren_nxt   = 1'b0;
                done_nxt     = 1'b0;
                if (start_flag) state_nxt = SET_I;
            end
            SET_I: begin
                i_nxt      = i + 8'd1;
                s_addr_nxt = i + 8'd1;
                state_nxt  = WAIT_I;
            end
            WAIT_I: state_nxt = GET_I;
            GET_I: begin
                si_nxt    = s_q;
                state_nxt = ADD_J;
            end
            ADD_J: begin
                j_nxt      = j + si;
                s_addr_nxt = j + si;
                state_nxt  = WAIT_J;
            end
            WAIT_J: state_nxt = GET_J;
            GET_J: begin
                // Set up the S[i] <= S[j] write so it is live during WR_I.
                sj_nxt     = s_q;
                s_addr_nxt = i;
                s_data_nxt = s_q;
                s_wren_nxt = 1'b1;
                state_nxt  = WR_I;
            end
            WR_I: begin
                // S[j] <= old S[i]; when i==j this rewrites the same value.
                s_addr_nxt = j;
                s_data_nxt = si;
                s_wren_nxt = 1'b1;
                state_nxt  = WR_J;
            end
            WR_J: begin
                s_wren_nxt = 1'b0;
                state_nxt  = SET_F;
            end
            SET_F: begin
                s_addr_nxt = si + sj;
                state_nxt  = WAIT_F;
            end
            WAIT_F: state_nxt = GET_F;
            GET_F: begin
                // f is captured here; the RAM write is prepared from the same
                // read so it is live during WR_D.
                f_nxt      = s_q;
                d_addr_nxt = k;
                d_data_nxt = s_q ^ rom_q;
                d_wren_nxt = 1'b1;
                state_nxt  = WR_D;
            end
            WR_D: begin
                d_data_nxt = f ^ rom_q;
                d_wren_nxt = 1'b0;
                state_nxt  = NEXT;
            end
            NEXT: begin
                if (k == MSG_AW'(MSG_LEN - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    k_nxt        = k + MSG_AW'(1);
                    rom_addr_nxt = k + MSG_AW'(1);
                    state_nxt    = SET_I;
                end
            end
            DONE: begin
                if (!start_flag) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                s_wren_nxt = 1'b0;
                d_wren_nxt = 1'b0;
                done_nxt   = 1'b0;
            end
        endcase
    end

endmodule
